// File: rtl/md_unit_iter_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   - op encodings (MD_*), mt_hilo encodings, FSM states
//   - small opcode decode helpers used by md_unit_iter
package md_unit_iter_pkg;

  localparam logic [2:0] MD_MULTU = 3'b000;
  localparam logic [2:0] MD_MULT  = 3'b001;
  localparam logic [2:0] MD_DIVU  = 3'b010;
  localparam logic [2:0] MD_DIV   = 3'b011;
  localparam logic [2:0] MD_MADDU = 3'b100;
  localparam logic [2:0] MD_MADD  = 3'b101;
  localparam logic [2:0] MD_MSUBU = 3'b110;
  localparam logic [2:0] MD_MSUB  = 3'b111;

  typedef enum logic [1:0] {
    MT_NONE = 2'b00,
    MT_LO   = 2'b01,
    MT_HI   = 2'b10,
    MT_RSVD = 2'b11
  } mt_hilo_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10
  } md_state_e;

  function automatic logic op_is_div(input logic [2:0] op);
    return (op == MD_DIVU) || (op == MD_DIV);
  endfunction

  function automatic logic op_is_macc(input logic [2:0] op);
    return (op == MD_MADDU) || (op == MD_MADD) || (op == MD_MSUBU) || (op == MD_MSUB);
  endfunction

  function automatic logic op_is_sub(input logic [2:0] op);
    return (op == MD_MSUBU) || (op == MD_MSUB);
  endfunction

  function automatic logic op_is_signed(input logic [2:0] op);
    return !((op == MD_MULTU) || (op == MD_DIVU) || (op == MD_MADDU) || (op == MD_MSUBU));
  endfunction

endpackage

// File: rtl/md_unit_iter_div_step.sv
// One combinational restoring-division step.
//   rem_i/quo_i : partial remainder and dividend/quotient shift register
//   div_i       : divisor magnitude
//   rem_o/quo_o : next remainder and quotient (new quotient bit in LSB)
//   borrow_o    : trial subtraction borrowed, i.e. quotient bit is 0
module md_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o,
  output logic             borrow_o
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  // Without a borrow the true difference is below 2^WIDTH, so a WIDTH-bit
  // subtract is exact.
  always_comb begin
    shifted  = {rem_i, quo_i[WIDTH-1]};
    borrow_o = (shifted < {1'b0, div_i});
    diff     = shifted[WIDTH-1:0] - div_i;
    if (borrow_o) begin
      rem_o = shifted[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end else begin
      rem_o = diff;
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/md_unit_iter.sv
// Iterative multiply/divide unit for the EX stage; owns HI/LO.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle.
// Optional feature macro: MD_MACC_EN (multiply-accumulate/subtract ops 1xx).
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   start, op         launch an op from IDLE (op latched)
//   mt_hilo, src_a    direct HI/LO writes in IDLE (01 LO, 10 HI)
//   src_a, src_b      operands (latched at start)
//   hi, lo            HI/LO registers
//   busy              op in flight
//   done              one-cycle pulse when HI/LO take the result
//   div0              sticky divide-by-zero flag, cleared at next start
module md_unit_iter
  import md_unit_iter_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [1:0]       mt_hilo,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div0
);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;       // multiplicand / divisor magnitude
  logic [WIDTH-1:0] acc_q, acc_d;   // product high half / partial remainder
  logic [WIDTH-1:0] x_q, x_d;       // multiplier / dividend -> product low / quotient
  logic             neg_q, neg_d;   // product or quotient must be negated
  logic             rneg_q, rneg_d; // remainder takes the dividend's sign
  logic             bz_q, bz_d;     // latched divisor-is-zero
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             div0_q, div0_d;

  logic [WIDTH-1:0] div_rem, div_quo;
  logic             div_borrow_unused;

  md_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_i    (acc_q),
    .quo_i    (x_q),
    .div_i    (a_q),
    .rem_o    (div_rem),
    .quo_o    (div_quo),
    .borrow_o (div_borrow_unused)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      acc_q   <= '0;
      x_q     <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      bz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      acc_q   <= acc_d;
      x_q     <= x_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      bz_q    <= bz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      div0_q  <= div0_d;
    end
  end

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s, mag_a, mag_b;
  logic               sa, sb, bz;

  // Next-state, datapath and outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    acc_d   = acc_q;
    x_d     = x_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    bz_d    = bz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    div0_d  = div0_q;

    sa    = op_is_signed(op) & src_a[WIDTH-1];
    sb    = op_is_signed(op) & src_b[WIDTH-1];
    bz    = (src_b == '0);
    mag_a = sa ? -src_a : src_a;
    mag_b = sb ? -src_b : src_b;

    mul_sum = {1'b0, acc_q} + {1'b0, (x_q[0] ? a_q : '0)};
    prod    = {acc_q, x_q};
    prod_s  = neg_q ? -prod : prod;
    quo_s   = neg_q ? -x_q : x_q;
    rem_s   = rneg_q ? -acc_q : acc_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d   = op;
          a_d    = mag_b;
          x_d    = mag_a;
          acc_d  = '0;
          cnt_d  = CNT_W'(WIDTH);
          bz_d   = bz;
          // A zero divisor keeps an all-ones quotient regardless of signs.
          neg_d  = op_is_div(op) ? ((sa ^ sb) & ~bz) : (sa ^ sb);
          rneg_d = sa;
          div0_d = 1'b0;
          busy_d = 1'b1;
          state_d = ST_CALC;
        end else if (mt_hilo == MT_LO) begin
          lo_d = src_a;
        end else if (mt_hilo == MT_HI) begin
          hi_d = src_a;
        end
      end

      ST_CALC: begin
        if (op_is_div(op_q)) begin
          acc_d = div_rem;
          x_d   = div_quo;
        end else begin
          {acc_d, x_d} = {mul_sum, x_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_FIX;
        end
      end

      ST_FIX: begin
        if (op_is_div(op_q)) begin
          lo_d = quo_s;
          hi_d = rem_s;
          if (bz_q) begin
            div0_d = 1'b1;
          end
        end else if (!op_is_macc(op_q)) begin
          {hi_d, lo_d} = prod_s;
        end
`ifdef MD_MACC_EN
        else if (op_is_sub(op_q)) begin
          {hi_d, lo_d} = {hi_q, lo_q} - prod_s;
        end else begin
          {hi_d, lo_d} = {hi_q, lo_q} + prod_s;
        end
`endif
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = busy_q;
  assign done = done_q;
  assign div0 = div0_q;

endmodule

// File: tb/tb_md_unit_iter.sv
// Directed bench for md_unit_iter (WIDTH=32): table of arithmetic vectors run
// back-to-back, plus sequences for mt_hilo, sticky div0, mid-op reset and
// the 1xx opcodes (MD_MACC_EN on or off).
module tb_md_unit_iter;
  import md_unit_iter_pkg::*;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [2:0]   op;
  logic [1:0]   mt_hilo;
  logic [W-1:0] src_a, src_b, hi, lo;
  logic         busy, done, div0;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] m_hi, m_lo;   // bench model of HI/LO

  always #5 clk = ~clk;

  md_unit_iter #(.WIDTH(W), .CNT_W(6)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .mt_hilo (mt_hilo),
    .src_a   (src_a),
    .src_b   (src_b),
    .hi      (hi),
    .lo      (lo),
    .busy    (busy),
    .done    (done),
    .div0    (div0)
  );

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] e_hi;
    logic [W-1:0] e_lo;
    logic         e_div0;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Launch at the current (post-negedge) point, follow busy, return in the done cycle.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [1:0] mt_start, input string tag);
    int n;
    start   = 1'b1;
    op      = o;
    src_a   = a;
    src_b   = b;
    mt_hilo = mt_start;
    @(negedge clk);
    start   = 1'b0;
    op      = 3'($urandom);
    src_a   = $urandom;
    src_b   = $urandom;
    mt_hilo = 2'($urandom_range(1, 2));
    check({tag, " busy_after_start"}, 64'(busy), 64'(1));
    check({tag, " done_after_start"}, 64'(done), 64'(0));
    check({tag, " div0_cleared"}, 64'(div0), 64'(0));
    check({tag, " hilo_at_start"}, {hi, lo}, {m_hi, m_lo});
    n = 0;
    while (busy && n < 200) begin
      n++;
      if (n == 16) check({tag, " hilo_mid"}, {hi, lo}, {m_hi, m_lo});
      @(negedge clk);
      src_a = $urandom;
    end
    mt_hilo = 2'b00;
    check({tag, " busy_cycles"}, 64'(n), 64'(W + 1));
    check({tag, " done_pulse"}, 64'(done), 64'(1));
  endtask

  initial begin
    bit seen_done;

    vecs[0]  = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1]  = '{MD_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[2]  = '{MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{MD_DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, 1'b1};
    vecs[4]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[5]  = '{MD_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};
    vecs[6]  = '{MD_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0};
    vecs[7]  = '{MD_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[8]  = '{MD_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
    vecs[9]  = '{MD_DIV,   32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1};
    vecs[10] = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[11] = '{MD_DIVU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0};

    reset = 1'b1; start = 1'b0; op = '0; mt_hilo = '0; src_a = '0; src_b = '0;
    m_hi = '0; m_lo = '0;
    repeat (3) @(negedge clk);
    check("reset hilo", {hi, lo}, 64'(0));
    check("reset busy", 64'(busy), 64'(0));
    check("reset done", 64'(done), 64'(0));
    check("reset div0", 64'(div0), 64'(0));
    reset = 1'b0;
    @(negedge clk);

    // Arithmetic vectors, each launched in the done cycle of the previous one.
    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 2'b00, $sformatf("vec%0d", i));
      check($sformatf("vec%0d hilo", i), {hi, lo}, {vecs[i].e_hi, vecs[i].e_lo});
      check($sformatf("vec%0d div0", i), 64'(div0), 64'(vecs[i].e_div0));
      m_hi = vecs[i].e_hi;
      m_lo = vecs[i].e_lo;
    end
    @(negedge clk);
    check("done single pulse", 64'(done), 64'(0));
    check("idle busy", 64'(busy), 64'(0));

    // Direct HI/LO writes in IDLE.
    mt_hilo = 2'b10; src_a = 32'h12345678;
    @(negedge clk);
    m_hi = 32'h12345678;
    check("mthi", {hi, lo}, {m_hi, m_lo});
    mt_hilo = 2'b01; src_a = 32'h00000005;
    @(negedge clk);
    m_lo = 32'h00000005;
    check("mtlo", {hi, lo}, {m_hi, m_lo});
    mt_hilo = 2'b11; src_a = 32'hDEADBEEF;
    @(negedge clk);
    check("mt reserved", {hi, lo}, {m_hi, m_lo});
    mt_hilo = 2'b00;

    // start and mt together: mt dropped (checked at start inside run_op).
    run_op(MD_MULTU, 32'h2, 32'h2, 2'b10, "start_mt");
    m_hi = 32'h0; m_lo = 32'h4;
    check("start_mt hilo", {hi, lo}, {m_hi, m_lo});

    // div0 stays set until the next start.
    run_op(MD_DIVU, 32'h9, 32'h0, 2'b00, "div0_set");
    m_hi = 32'h9; m_lo = 32'hFFFFFFFF;
    check("div0_set hilo", {hi, lo}, {m_hi, m_lo});
    repeat (3) @(negedge clk);
    check("div0 sticky", 64'(div0), 64'(1));

`ifdef MD_MACC_EN
    mt_hilo = 2'b10; src_a = 32'h0;
    @(negedge clk);
    mt_hilo = 2'b01; src_a = 32'h5;
    @(negedge clk);
    mt_hilo = 2'b00;
    m_hi = 32'h0; m_lo = 32'h5;
    check("macc preset", {hi, lo}, {m_hi, m_lo});
    run_op(MD_MADDU, 32'h3, 32'h4, 2'b00, "maddu");
    m_hi = 32'h0; m_lo = 32'h11;
    check("maddu hilo", {hi, lo}, {m_hi, m_lo});
    run_op(MD_MSUBU, 32'h3, 32'h6, 2'b00, "msubu");
    m_hi = 32'hFFFFFFFF; m_lo = 32'hFFFFFFFF;
    check("msubu hilo", {hi, lo}, {m_hi, m_lo});
    run_op(MD_MADD, 32'hFFFFFFFF, 32'h1, 2'b00, "madd");
    m_hi = 32'hFFFFFFFF; m_lo = 32'hFFFFFFFE;
    check("madd hilo", {hi, lo}, {m_hi, m_lo});
    run_op(MD_MSUB, 32'hFFFFFFFE, 32'hFFFFFFFF, 2'b00, "msub");
    m_hi = 32'hFFFFFFFF; m_lo = 32'hFFFFFFFC;
    check("msub hilo", {hi, lo}, {m_hi, m_lo});
`else
    run_op(MD_MADDU, 32'h7, 32'h9, 2'b00, "op1xx");
    check("op1xx hilo unchanged", {hi, lo}, {m_hi, m_lo});
    run_op(MD_MSUB, 32'hFFFFFFFF, 32'h3, 2'b00, "op1xx_b");
    check("op1xx_b hilo unchanged", {hi, lo}, {m_hi, m_lo});
`endif

    // Reset in the middle of a divide (count == 10) abandons it.
    start = 1'b1; op = MD_DIV; src_a = 32'h64; src_b = 32'h3;
    @(negedge clk);
    start = 1'b0;
    repeat (22) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    check("midreset busy", 64'(busy), 64'(0));
    check("midreset hilo", {hi, lo}, 64'(0));
    check("midreset done", 64'(done), 64'(0));
    check("midreset div0", 64'(div0), 64'(0));
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    check("midreset no done", 64'(seen_done), 64'(0));
    check("midreset hilo later", {hi, lo}, 64'(0));

    run_op(MD_MULT, 32'h7, 32'hFFFFFFFD, 2'b00, "recover");
    check("recover hilo", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFEB});
    @(negedge clk);
    check("recover done low", 64'(done), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
